// File: rtl/sys_view_pkg.sv
// Shared types and constants for the CPU snapshot read-out path:
// FSM states, frame geometry, the snapshot record and its byte selector.
package sys_view_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    localparam int SNAP_WORDS  = 11;
    localparam int SNAP_BYTES  = 22;
    localparam int FRAME_BYTES = 24;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam logic [4:0] LAST_IDX          = 5'(SNAP_BYTES - 1);

    typedef struct packed {
        logic [7:0][15:0] regs;
        logic [15:0]      psw;
        logic [15:0]      pc;
        logic [15:0]      inst;
    } snap_t;

    // Word order R0..R7, PSW, PC, INST; even index is the high byte.
    function automatic logic [7:0] snap_byte(input snap_t s, input logic [4:0] idx);
        logic [3:0]  word;
        logic [15:0] w;
        word = idx[4:1];
        w    = 16'h0000;
        if (word < 4'd8) begin
            w = s.regs[word[2:0]];
        end else begin
            case (word)
                4'd8:    w = s.psw;
                4'd9:    w = s.pc;
                4'd10:   w = s.inst;
                default: w = 16'h0000;
            endcase
        end
        return idx[0] ? w[7:0] : w[15:8];
    endfunction

endpackage

// File: rtl/sys_snapshot_reader.sv
// Captures one register bank plus PSW/PC/INST on request and streams it as
// SYNC, 22 data bytes and an 8-bit additive checksum over valid/ready.
module sys_snapshot_reader
    import sys_view_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         BANK      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0][7:0][15:0]  gprc,
    input  logic [15:0]            psw,
    input  logic [15:0]            pc,
    input  logic [15:0]            inst,
    input  logic                   req,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    // Handshake: a byte moves on a rising clk edge where out_valid and
    // out_ready are both high; out_* are held unchanged until that edge.
    localparam logic BANK_SEL = BANK[0];

    state_t     state_q, state_d;
    snap_t      shadow_q, shadow_d;
    logic [7:0] sum_q, sum_d;
    logic [4:0] idx_q, idx_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_last_q, out_last_d;

    logic       xfer;
    snap_t      capture;
    logic [7:0] sum_next;

    always_comb begin
        capture.regs = gprc[BANK_SEL];
        capture.psw  = psw;
        capture.pc   = pc;
        capture.inst = inst;
    end

    assign xfer     = out_valid_q & out_ready;
    assign sum_next = sum_q + out_data_q;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    shadow_d    = capture;
                    sum_d       = 8'h00;
                    idx_d       = 5'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = SYNC_BYTE;
                    out_last_d  = 1'b0;
                    state_d     = SYNC;
                end
            end
            SYNC: begin
                if (xfer) begin
                    out_data_d = snap_byte(shadow_q, 5'd0);
                    state_d    = DATA;
                end
            end
            DATA: begin
                // The byte leaving now is folded in; the next one is preloaded.
                if (xfer) begin
                    sum_d = sum_next;
                    if (idx_q == LAST_IDX) begin
                        out_data_d = sum_next;
                        out_last_d = 1'b1;
                        state_d    = CSUM;
                    end else begin
                        idx_d      = idx_q + 5'd1;
                        out_data_d = snap_byte(shadow_q, idx_q + 5'd1);
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    out_data_d  = 8'h00;
                    out_last_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            sum_q       <= 8'h00;
            idx_q       <= 5'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sys_snapshot_reader.sv
// Bench for sys_snapshot_reader: a frame-level model (list of 24 expected
// bytes built at capture) is compared against two instances (BANK 0 and 1).
module tb_sys_snapshot_reader;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0][7:0][15:0] gprc;
    logic [15:0]           psw, pc, inst;
    logic                  req, out_ready;

    logic       ov0, ol0, bz0, ov1, ol1, bz1;
    logic [7:0] od0, od1;
    logic [1:0] st0, st1;

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sys_snapshot_reader #(.SYNC_BYTE(8'hA5), .BANK(0)) dut0 (
        .clk(clk), .rst(rst), .gprc(gprc), .psw(psw), .pc(pc), .inst(inst),
        .req(req), .out_ready(out_ready), .out_valid(ov0), .out_data(od0),
        .out_last(ol0), .busy(bz0), .dbg_state(st0)
    );

    sys_snapshot_reader #(.SYNC_BYTE(8'hA5), .BANK(1)) dut1 (
        .clk(clk), .rst(rst), .gprc(gprc), .psw(psw), .pc(pc), .inst(inst),
        .req(req), .out_ready(out_ready), .out_valid(ov1), .out_data(od1),
        .out_last(ol1), .busy(bz1), .dbg_state(st1)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0] m_frame [2][24];
    bit         m_active;
    int         m_pos;

    task automatic build_frames();
        logic [15:0] words [11];
        logic [7:0]  b, sum;
        for (int bk = 0; bk < 2; bk++) begin
            for (int r = 0; r < 8; r++) words[r] = gprc[bk][r];
            words[8]  = psw;
            words[9]  = pc;
            words[10] = inst;
            m_frame[bk][0] = 8'hA5;
            sum = 8'h00;
            for (int i = 0; i < 22; i++) begin
                b = (i % 2 == 0) ? words[i / 2][15:8] : words[i / 2][7:0];
                m_frame[bk][1 + i] = b;
                sum = sum + b;
            end
            m_frame[bk][23] = sum;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0;
            m_pos    = 0;
        end else if (!m_active) begin
            if (req) begin
                build_frames();
                m_active = 1;
                m_pos    = 0;
            end
        end else if (out_ready) begin
            m_pos++;
            if (m_pos == 24) begin
                m_active = 0;
                m_pos    = 0;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [7:0] obs0_q[$];
    logic [7:0] obs1_q[$];
    logic       last_q[$];

    task automatic check_dut(int bk, logic v, logic [7:0] d, logic l, logic bz);
        if (rst) begin
            chk($sformatf("rst_valid%0d", bk), v, 0);
            chk($sformatf("rst_data%0d", bk), d, 0);
            chk($sformatf("rst_last%0d", bk), l, 0);
            chk($sformatf("rst_busy%0d", bk), bz, 0);
        end else begin
            chk($sformatf("valid%0d", bk), v, m_active);
            chk($sformatf("busy%0d", bk), bz, m_active);
            chk($sformatf("last%0d", bk), l, (m_active && m_pos == 23));
            if (m_active) chk($sformatf("data%0d_pos%0d", bk, m_pos), d, m_frame[bk][m_pos]);
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, ov0, od0, ol0, bz0);
        check_dut(1, ov1, od1, ol1, bz1);
        if (!rst && ov0 && out_ready) begin
            obs0_q.push_back(od0);
            last_q.push_back(ol0);
        end
        if (!rst && ov1 && out_ready) obs1_q.push_back(od1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_obs();
        obs0_q.delete();
        obs1_q.delete();
        last_q.delete();
    endtask

    task automatic set_zero();
        gprc = '0;
        psw  = 16'h0;
        pc   = 16'h0;
        inst = 16'h0;
    endtask

    task automatic randomize_snap();
        for (int bk = 0; bk < 2; bk++)
            for (int r = 0; r < 8; r++) gprc[bk][r] = 16'($urandom);
        psw  = 16'($urandom);
        pc   = 16'($urandom);
        inst = 16'($urandom);
    endtask

    // mode 0: ready=1; 1: ready pattern 1,0,0,1; 2: random ready;
    // 3: ready=1 with req held high; 4: random ready, req and inputs
    task automatic run_frame(int mode);
        int n;
        clear_obs();
        req = 1'b1;
        out_ready = (mode == 2 || mode == 4) ? 1'($urandom_range(0, 1)) : 1'b1;
        tick(1);
        chk("capture_valid", ov0, 1'b1);
        chk("capture_sync", od0, 8'hA5);
        n = 0;
        while (bz0 && n < 400) begin
            case (mode)
                0: begin req = 1'b0; out_ready = 1'b1; end
                1: begin req = 1'b0; out_ready = (n % 4 == 0 || n % 4 == 3); end
                2: begin req = 1'b0; out_ready = 1'($urandom_range(0, 1)); end
                3: begin req = 1'b1; out_ready = 1'b1; end
                default: begin
                    req = 1'($urandom_range(0, 1));
                    out_ready = 1'($urandom_range(0, 1));
                    randomize_snap();
                end
            endcase
            tick(1);
            n++;
        end
        req = 1'b0;
        chk("frame_done_in_budget", bz0, 1'b0);
        chk("frame_len", obs0_q.size(), 24);
    endtask

    task automatic scen1_inputs();
        set_zero();
        pc   = 16'h0100;
        inst = 16'h1234;
    endtask

    // ---------------- main sequence ----------------
    logic [7:0] saved1[$];
    int         lasts;

    initial begin
        rst = 1'b1;
        req = 1'b0;
        out_ready = 1'b0;
        set_zero();
        tick(3);
        chk("reset_valid", ov0, 0);
        chk("reset_busy", bz0, 0);
        rst = 1'b0;
        tick(2);

        // basic frame
        scen1_inputs();
        run_frame(0);
        saved1 = obs0_q;
        chk("s1_sync", obs0_q[0], 8'hA5);
        chk("s1_r7lo", obs0_q[16], 8'h00);
        chk("s1_pc_hi", obs0_q[19], 8'h01);
        chk("s1_pc_lo", obs0_q[20], 8'h00);
        chk("s1_inst_hi", obs0_q[21], 8'h12);
        chk("s1_inst_lo", obs0_q[22], 8'h34);
        chk("s1_csum", obs0_q[23], 8'h47);
        lasts = 0;
        foreach (last_q[i]) lasts += int'(last_q[i]);
        chk("s1_last_count", lasts, 1);
        chk("s1_last_pos", last_q[23], 1'b1);
        chk("s1_idle_after", ov0, 1'b0);
        tick(2);

        // checksum wrap
        set_zero();
        gprc[0][0] = 16'hFFFF;
        gprc[0][1] = 16'hFFFF;
        run_frame(0);
        chk("s2_csum_dut", obs0_q[23], 8'hFC);
        chk("s2_csum_model", m_frame[0][23], 8'hFC);
        tick(1);

        // stalls
        scen1_inputs();
        run_frame(1);
        for (int i = 0; i < 24; i++) chk($sformatf("s3_byte%0d", i), obs0_q[i], saved1[i]);
        tick(1);

        // input churn and req during frame, plus req held through CSUM
        scen1_inputs();
        run_frame(4);
        run_frame(3);
        tick(6);
        chk("s4_no_second_frame", ov0, 1'b0);
        chk("s4_not_busy", bz0, 1'b0);

        // reset on the 10th byte
        scen1_inputs();
        clear_obs();
        req = 1'b1;
        out_ready = 1'b1;
        tick(1);
        req = 1'b0;
        for (int n = 0; n < 50 && obs0_q.size() < 9; n++) tick(1);
        chk("s5_reached_byte10", obs0_q.size(), 9);
        rst = 1'b1;
        #1;
        chk("s5_async_valid", ov0, 0);
        chk("s5_async_data", od0, 0);
        chk("s5_async_last", ol0, 0);
        chk("s5_async_busy", bz0, 0);
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("s5_no_resume", ov0, 1'b0);
        run_frame(0);
        for (int i = 0; i < 24; i++) chk($sformatf("s5_byte%0d", i), obs0_q[i], saved1[i]);
        tick(1);

        // bank selection
        set_zero();
        gprc[1][3] = 16'hBEEF;
        run_frame(0);
        chk("s6_bank1_hi", obs1_q[7], 8'hBE);
        chk("s6_bank1_lo", obs1_q[8], 8'hEF);
        chk("s6_bank0_hi", obs0_q[7], 8'h00);
        tick(1);

        // randomized frames
        for (int f = 0; f < 30; f++) begin
            randomize_snap();
            run_frame($urandom_range(0, 4));
            tick($urandom_range(0, 3));
        end

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
